program_streamer: RTL

PROGRAM_STREAMER -- requirements
Module: program_streamer

---
 rtl/program_streamer.sv | 318 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/program_streamer.sv
// program_streamer: walks a block-structured program held in a synchronous ROM
// and presents each block header and its data bytes on valid/ready streams.
module program_streamer #(
    parameter int PROGRAM_SIZE   = 16,
    parameter int PROG_ADDR_BITS = $clog2(PROGRAM_SIZE),
    parameter int ADDR_BYTES     = 2,
    parameter bit CHECKSUM_EN    = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [PROG_ADDR_BITS-1:0] prog_addr,
    input  logic [7:0]                prog_data,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      err_checksum,
    output logic                      err_overrun,
    output logic                      hdr_valid,
    input  logic                      hdr_ready,
    output logic [7:0]                hdr_length,
    output logic [8*ADDR_BYTES-1:0]   hdr_address,
    output logic [7:0]                hdr_type,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic [7:0]                data_byte,
    output logic                      data_last,
    output logic [15:0]               block_count
);

    localparam int AW = 8 * ADDR_BYTES;
    localparam logic [PROG_ADDR_BITS:0] LIMIT = (PROG_ADDR_BITS + 1)'(PROGRAM_SIZE);
    localparam logic [PROG_ADDR_BITS:0] PTR_ONE = (PROG_ADDR_BITS + 1)'(1);
    localparam logic [2:0] TYPE_IDX = 3'(ADDR_BYTES + 1);
    localparam logic [7:0] EOP_TYPE = 8'h01;

    typedef enum logic [2:0] {
        IDLE,
        HDR_FETCH,
        HDR_OUT,
        DATA,
        CSUM,
        EOP
    } state_t;

    state_t                    state_q, state_d;
    logic [PROG_ADDR_BITS-1:0] prog_addr_q, prog_addr_d;
    logic [PROG_ADDR_BITS:0]   ptr_q, ptr_d;
    logic                      issued_q, issued_d;
    logic                      avail_q, avail_d;
    logic [2:0]                hidx_q, hidx_d;
    logic [7:0]                len_q, len_d;
    logic [AW-1:0]             addr_q, addr_d;
    logic [7:0]                typ_q, typ_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [7:0]                sum_q, sum_d;
    logic                      dvalid_q, dvalid_d;
    logic [7:0]                dbyte_q, dbyte_d;
    logic                      dlast_q, dlast_d;
    logic                      done_q, done_d;
    logic                      err_cs_q, err_cs_d;
    logic                      err_ov_q, err_ov_d;
    logic [15:0]               blk_q, blk_d;

    logic       want;
    logic       need;
    logic       take;
    logic       in_range;
    logic       issue;
    logic       starve;
    logic [7:0] byte_sum;

    assign in_range = ptr_q < LIMIT;
    assign issue    = need && !issued_q && (!avail_q || take) && in_range;
    assign starve   = want && !issued_q && !avail_q && !in_range;
    assign byte_sum = sum_q + prog_data;

    assign prog_addr    = prog_addr_q;
    assign busy         = state_q != IDLE;
    assign done         = done_q;
    assign err_checksum = err_cs_q;
    assign err_overrun  = err_ov_q;
    assign hdr_valid    = state_q == HDR_OUT;
    assign hdr_length   = len_q;
    assign hdr_address  = addr_q;
    assign hdr_type     = typ_q;
    assign data_valid   = dvalid_q;
    assign data_byte    = dbyte_q;
    assign data_last    = dlast_q;
    assign block_count  = blk_q;

    // Fetch demand: want = byte needed now, need = prefetch allowed, take = consume ROM byte.
    always_comb begin
        want = 1'b0;
        need = 1'b0;
        take = 1'b0;
        unique case (state_q)
            HDR_FETCH: begin
                want = 1'b1;
                take = avail_q;
                need = !(take && hidx_q == TYPE_IDX && prog_data == EOP_TYPE);
            end
            HDR_OUT: begin
                need = typ_q != EOP_TYPE;
            end
            DATA: begin
                want = cnt_q != len_q;
                take = avail_q && want && (!dvalid_q || data_ready);
                need = 1'b1;
            end
            CSUM: begin
                want = 1'b1;
                take = avail_q;
                need = 1'b1;
            end
            default: begin
                need = 1'b0;
            end
        endcase
    end

    // Next-state logic: ROM fetch pipeline, block parsing and run control.
    always_comb begin
        state_d     = state_q;
        prog_addr_d = prog_addr_q;
        ptr_d       = ptr_q;
        issued_d    = issued_q;
        avail_d     = avail_q;
        hidx_d      = hidx_q;
        len_d       = len_q;
        addr_d      = addr_q;
        typ_d       = typ_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        dvalid_d    = dvalid_q;
        dbyte_d     = dbyte_q;
        dlast_d     = dlast_q;
        done_d      = done_q;
        err_cs_d    = err_cs_q;
        err_ov_d    = err_ov_q;
        blk_d       = blk_q;

        if (issued_q) begin
            issued_d = 1'b0;
            avail_d  = 1'b1;
        end else if (take) begin
            avail_d = 1'b0;
        end
        if (issue) begin
            prog_addr_d = ptr_q[PROG_ADDR_BITS-1:0];
            ptr_d       = ptr_q + PTR_ONE;
            issued_d    = 1'b1;
            avail_d     = 1'b0;
        end
        if (take) begin
            sum_d = byte_sum;
        end

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d     = HDR_FETCH;
                    prog_addr_d = '0;
                    ptr_d       = PTR_ONE;
                    issued_d    = 1'b1;
                    avail_d     = 1'b0;
                    hidx_d      = 3'd0;
                    sum_d       = 8'd0;
                    done_d      = 1'b0;
                    err_cs_d    = 1'b0;
                    err_ov_d    = 1'b0;
                    blk_d       = 16'd0;
                end
            end
            HDR_FETCH: begin
                if (take) begin
                    unique case (1'b1)
                        hidx_q == 3'd0: begin
                            len_d  = prog_data;
                            hidx_d = hidx_q + 3'd1;
                        end
                        hidx_q == TYPE_IDX: begin
                            typ_d   = prog_data;
                            hidx_d  = 3'd0;
                            state_d = HDR_OUT;
                        end
                        default: begin
                            addr_d = {addr_q[AW-9:0], prog_data};
                            hidx_d = hidx_q + 3'd1;
                        end
                    endcase
                end
                if (starve) begin
                    err_ov_d = 1'b1;
                    state_d  = EOP;
                end
            end
            HDR_OUT: begin
                if (hdr_ready) begin
                    blk_d = (blk_q == 16'hFFFF) ? blk_q : blk_q + 16'd1;
                    cnt_d = 8'd0;
                    if (typ_q == EOP_TYPE) begin
                        state_d = EOP;
                    end else if (len_q == 8'd0) begin
                        if (CHECKSUM_EN) begin
                            state_d = CSUM;
                        end else begin
                            state_d = HDR_FETCH;
                            sum_d   = 8'd0;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (take) begin
                    dbyte_d  = prog_data;
                    dlast_d  = cnt_q == len_q - 8'd1;
                    dvalid_d = 1'b1;
                    cnt_d    = cnt_q + 8'd1;
                end else if (dvalid_q && data_ready) begin
                    dvalid_d = 1'b0;
                end
                if (dvalid_q && data_ready && dlast_q) begin
                    dlast_d = 1'b0;
                    if (CHECKSUM_EN) begin
                        state_d = CSUM;
                    end else begin
                        state_d = HDR_FETCH;
                        sum_d   = 8'd0;
                    end
                end
                if (starve) begin
                    err_ov_d = 1'b1;
                    dvalid_d = 1'b0;
                    dlast_d  = 1'b0;
                    state_d  = EOP;
                end
            end
            CSUM: begin
                if (take) begin
                    if (byte_sum != 8'd0) begin
                        err_cs_d = 1'b1;
                        state_d  = EOP;
                    end else begin
                        sum_d   = 8'd0;
                        state_d = HDR_FETCH;
                    end
                end
                if (starve) begin
                    err_ov_d = 1'b1;
                    state_d  = EOP;
                end
            end
            EOP: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && state_q != IDLE) begin
            state_d  = IDLE;
            dvalid_d = 1'b0;
            dlast_d  = 1'b0;
            issued_d = 1'b0;
            avail_d  = 1'b0;
            done_d   = 1'b0;
        end
    end

    // State register; reset drops every output to zero at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prog_addr_q <= '0;
            ptr_q       <= '0;
            issued_q    <= 1'b0;
            avail_q     <= 1'b0;
            hidx_q      <= 3'd0;
            len_q       <= 8'd0;
            addr_q      <= '0;
            typ_q       <= 8'd0;
            cnt_q       <= 8'd0;
            sum_q       <= 8'd0;
            dvalid_q    <= 1'b0;
            dbyte_q     <= 8'd0;
            dlast_q     <= 1'b0;
            done_q      <= 1'b0;
            err_cs_q    <= 1'b0;
            err_ov_q    <= 1'b0;
            blk_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            prog_addr_q <= prog_addr_d;
            ptr_q       <= ptr_d;
            issued_q    <= issued_d;
            avail_q     <= avail_d;
            hidx_q      <= hidx_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            typ_q       <= typ_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            dvalid_q    <= dvalid_d;
            dbyte_q     <= dbyte_d;
            dlast_q     <= dlast_d;
            done_q      <= done_d;
            err_cs_q    <= err_cs_d;
            err_ov_q    <= err_ov_d;
            blk_q       <= blk_d;
        end
    end

endmodule
